// File: rtl/microwave_pkg.sv
// Shared types and default parameters for the microwave front-panel controller.
package microwave_pkg;

    localparam int TIME_W       = 4;
    localparam int TMAX_DEF     = 15;
    localparam int BEEP_CYC_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector: one pulse per low-to-high transition of a level input.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/microwave_panel.sv
// Front-panel controller: turns button presses and the door switch into cook time,
// run request and a completion beep for the downstream oven stage.
module microwave_panel
    import microwave_pkg::*;
#(
    parameter int TMAX     = TMAX_DEF,
    parameter int BEEP_CYC = BEEP_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              door,
    input  logic              p,
    output logic [TIME_W-1:0] tin,
    output logic              r,
    output logic              beep,
    output logic [1:0]        state
);

    localparam int                 CNT_W     = $clog2(BEEP_CYC + 1);
    localparam logic [TIME_W-1:0]  TMAX_T    = TIME_W'(TMAX);
    localparam logic [CNT_W-1:0]   BEEP_LAST = CNT_W'(BEEP_CYC);

    logic up_ev;
    logic dn_ev;
    logic start_ev;
    logic stop_ev;
    logic any_ev;

    edge_det u_up    (.clk(clk), .rst(rst), .level(btn_up),    .pulse(up_ev));
    edge_det u_dn    (.clk(clk), .rst(rst), .level(btn_dn),    .pulse(dn_ev));
    edge_det u_start (.clk(clk), .rst(rst), .level(btn_start), .pulse(start_ev));
    edge_det u_stop  (.clk(clk), .rst(rst), .level(btn_stop),  .pulse(stop_ev));

    assign any_ev = up_ev | dn_ev | start_ev | stop_ev;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] tin_q, tin_d;
    logic              r_q, r_d;
    logic              beep_q, beep_d;
    logic              p_seen_q, p_seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The highest-priority press selects the action; if that action is ignored
    // in the current state, lower-priority presses do not get a turn.
    always_comb begin
        state_d  = state_q;
        tin_d    = tin_q;
        p_seen_d = 1'b0;
        cnt_d    = '0;

        case (state_q)
            ST_IDLE: begin
                tin_d = '0;
                if (!stop_ev && !start_ev && up_ev) begin
                    tin_d   = TIME_W'(1);
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                if (stop_ev) begin
                    tin_d   = '0;
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    if (!door) begin
                        state_d = ST_RUN;
                    end
                end else if (up_ev) begin
                    if (tin_q < TMAX_T) begin
                        tin_d = tin_q + TIME_W'(1);
                    end
                end else if (dn_ev) begin
                    if (tin_q <= TIME_W'(1)) begin
                        tin_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tin_d = tin_q - TIME_W'(1);
                    end
                end
            end

            ST_RUN: begin
                // Pause beats completion when both happen in the same cycle.
                if (stop_ev || door) begin
                    state_d = ST_SET;
                end else if (p_seen_q && !p) begin
                    tin_d   = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_DONE;
                end else begin
                    p_seen_d = p_seen_q | p;
                end
            end

            ST_DONE: begin
                tin_d = '0;
                if (any_ev || (cnt_q == BEEP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                tin_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        r_d    = (state_d == ST_RUN);
        beep_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tin_q    <= '0;
            r_q      <= 1'b0;
            beep_q   <= 1'b0;
            p_seen_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tin_q    <= tin_d;
            r_q      <= r_d;
            beep_q   <= beep_d;
            p_seen_q <= p_seen_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tin   = tin_q;
    assign r     = r_q;
    assign beep  = beep_q;
    assign state = state_q;

endmodule

// File: tb/tb_microwave_panel.sv
// Self-checking bench for microwave_panel: vector table, directed corner cases and
// randomized traffic checked against a behavioural model of the panel rules.
module tb_microwave_panel;

    localparam int TMAX     = 15;
    localparam int BEEP_CYC = 8;

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_UP    = 4'b0001;
    localparam logic [3:0] B_DN    = 4'b0010;
    localparam logic [3:0] B_START = 4'b0100;
    localparam logic [3:0] B_STOP  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_start = 1'b0, btn_stop = 1'b0;
    logic       door = 1'b0;
    logic       p = 1'b0;
    logic [3:0] tin;
    logic       r;
    logic       beep;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    microwave_panel #(.TMAX(TMAX), .BEEP_CYC(BEEP_CYC)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_start(btn_start), .btn_stop(btn_stop),
        .door(door), .p(p),
        .tin(tin), .r(r), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 setting, 2 running, 3 beeping.
    int m_mode = 0;
    int m_time = 0;
    bit m_power_seen = 1'b0;
    int m_beep_left = 0;
    bit m_prev[4] = '{default: 1'b0};

    task automatic modelStep(input logic [3:0] btn, input logic dr, input logic pp, input logic rs);
        bit ev[4];
        for (int i = 0; i < 4; i++) begin
            ev[i] = btn[i] && !m_prev[i];
        end
        if (rs) begin
            m_mode = 0; m_time = 0; m_power_seen = 0; m_beep_left = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) m_prev[i] = btn[i];
            case (m_mode)
                0: if (!ev[3] && !ev[2] && ev[0]) begin m_mode = 1; m_time = 1; end
                1: begin
                    if (ev[3]) begin m_mode = 0; m_time = 0; end
                    else if (ev[2]) begin
                        if (!dr) begin m_mode = 2; m_power_seen = 0; end
                    end else if (ev[0]) m_time = (m_time + 1 > TMAX) ? TMAX : m_time + 1;
                    else if (ev[1]) begin
                        m_time = m_time - 1;
                        if (m_time <= 0) begin m_time = 0; m_mode = 0; end
                    end
                end
                2: begin
                    if (ev[3] || dr) m_mode = 1;
                    else if (m_power_seen && !pp) begin m_mode = 3; m_time = 0; m_beep_left = BEEP_CYC; end
                    else if (pp) m_power_seen = 1;
                end
                default: begin
                    if (ev[0] || ev[1] || ev[2] || ev[3]) m_mode = 0;
                    else begin
                        m_beep_left = m_beep_left - 1;
                        if (m_beep_left == 0) m_mode = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".tin"},   int'(tin),   m_time);
        checkVal({tag, ".r"},     int'(r),     (m_mode == 2) ? 1 : 0);
        checkVal({tag, ".beep"},  int'(beep),  (m_mode == 3) ? 1 : 0);
        checkVal({tag, ".state"}, int'(state), m_mode);
    endtask

    task automatic applyStimulus(input logic [3:0] btn, input logic dr, input logic pp,
                                 input logic rs, input string tag);
        btn_up    = btn[0];
        btn_dn    = btn[1];
        btn_start = btn[2];
        btn_stop  = btn[3];
        door      = dr;
        p         = pp;
        rst       = rs;
        @(posedge clk);
        modelStep(btn, dr, pp, rs);
        #1;
        checkOutput(tag);
    endtask

    task automatic press(input logic [3:0] btn, input string tag);
        applyStimulus(btn, 1'b0, 1'b0, 1'b0, tag);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, tag);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       dr;
        logic       pp;
        int         exp_tin;
        int         exp_r;
        int         exp_beep;
        int         exp_state;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int beep_cycles;

        vecs[0]  = '{B_UP,    0, 0, 1, 0, 0, 1};
        vecs[1]  = '{B_UP,    0, 0, 1, 0, 0, 1};
        vecs[2]  = '{B_NONE,  0, 0, 1, 0, 0, 1};
        vecs[3]  = '{B_UP,    0, 0, 2, 0, 0, 1};
        vecs[4]  = '{B_UP,    0, 0, 2, 0, 0, 1};
        vecs[5]  = '{B_NONE,  0, 0, 2, 0, 0, 1};
        vecs[6]  = '{B_UP,    0, 0, 3, 0, 0, 1};
        vecs[7]  = '{B_UP,    0, 0, 3, 0, 0, 1};
        vecs[8]  = '{B_NONE,  0, 0, 3, 0, 0, 1};
        vecs[9]  = '{B_DN,    0, 0, 2, 0, 0, 1};
        vecs[10] = '{B_NONE,  0, 0, 2, 0, 0, 1};
        vecs[11] = '{B_DN,    0, 0, 1, 0, 0, 1};
        vecs[12] = '{B_NONE,  0, 0, 1, 0, 0, 1};
        vecs[13] = '{B_DN,    0, 0, 0, 0, 0, 0};
        vecs[14] = '{B_NONE,  0, 0, 0, 0, 0, 0};
        vecs[15] = '{B_START, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{B_NONE,  0, 0, 0, 0, 0, 0};

        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b1, "reset");
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b1, "reset");
        checkVal("reset_state", int'(state), 0);
        checkVal("reset_tin", int'(tin), 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btn, vecs[i].dr, vecs[i].pp, 1'b0, "vec");
            checkVal($sformatf("vec%0d.tin", i),   int'(tin),   vecs[i].exp_tin);
            checkVal($sformatf("vec%0d.r", i),     int'(r),     vecs[i].exp_r);
            checkVal($sformatf("vec%0d.beep", i),  int'(beep),  vecs[i].exp_beep);
            checkVal($sformatf("vec%0d.state", i), int'(state), vecs[i].exp_state);
        end

        // Saturation at TMAX, then a long hold counts as a single press.
        for (int i = 0; i < 20; i++) press(B_UP, "sat");
        checkVal("sat_tin", int'(tin), 15);
        checkVal("sat_state", int'(state), 1);
        press(B_DN, "sat");
        press(B_DN, "sat");
        for (int i = 0; i < 10; i++) applyStimulus(B_UP, 1'b0, 1'b0, 1'b0, "hold");
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "hold");
        checkVal("hold_tin", int'(tin), 14);
        press(B_STOP, "clear");
        checkVal("clear_state", int'(state), 0);

        // Door interlock on start, then door opening mid-run.
        for (int i = 0; i < 5; i++) press(B_UP, "set5");
        applyStimulus(B_START, 1'b1, 1'b0, 1'b0, "door_start");
        checkVal("door_start_state", int'(state), 1);
        checkVal("door_start_r", int'(r), 0);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "door_close");
        applyStimulus(B_START, 1'b0, 1'b0, 1'b0, "start");
        checkVal("start_r", int'(r), 1);
        checkVal("start_state", int'(state), 2);
        applyStimulus(B_NONE, 1'b1, 1'b0, 1'b0, "door_open");
        checkVal("pause_r", int'(r), 0);
        checkVal("pause_state", int'(state), 1);
        checkVal("pause_tin", int'(tin), 5);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "door_shut");

        // Completion and beep length.
        press(B_START, "run");
        for (int i = 0; i < 6; i++) applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0, "power");
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "done");
        checkVal("done_state", int'(state), 3);
        checkVal("done_tin", int'(tin), 0);
        beep_cycles = beep ? 1 : 0;
        for (int i = 0; i < 20 && beep; i++) begin
            applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "beep");
            if (beep) beep_cycles++;
        end
        checkVal("beep_len", beep_cycles, BEEP_CYC);
        checkVal("after_beep_state", int'(state), 0);
        checkVal("after_beep_tin", int'(tin), 0);

        // Stop in the same cycle as p falls: pause wins, no beep.
        for (int i = 0; i < 5; i++) press(B_UP, "set5b");
        press(B_START, "run2");
        applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0, "power2");
        applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0, "power2");
        applyStimulus(B_STOP, 1'b0, 1'b0, 1'b0, "stop_fall");
        checkVal("stop_fall_state", int'(state), 1);
        checkVal("stop_fall_beep", int'(beep), 0);
        checkVal("stop_fall_tin", int'(tin), 5);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "release");

        // Press during beep cuts it short.
        press(B_START, "run3");
        applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0, "power3");
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "done3");
        checkVal("done3_state", int'(state), 3);
        applyStimulus(B_UP, 1'b0, 1'b0, 1'b0, "cut");
        checkVal("cut_state", int'(state), 0);
        checkVal("cut_beep", int'(beep), 0);
        checkVal("cut_tin", int'(tin), 0);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "release");

        // Reset while running.
        press(B_UP, "set1");
        press(B_START, "run4");
        applyStimulus(B_NONE, 1'b0, 1'b1, 1'b1, "rst_run");
        checkVal("rst_run_r", int'(r), 0);
        checkVal("rst_run_tin", int'(tin), 0);
        checkVal("rst_run_state", int'(state), 0);
        checkVal("rst_run_beep", int'(beep), 0);
        applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0, "post_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] btn;
            logic       dr, pp, rs;
            btn[0] = ($urandom_range(0, 2) == 0);
            btn[1] = ($urandom_range(0, 4) == 0);
            btn[2] = ($urandom_range(0, 3) == 0);
            btn[3] = ($urandom_range(0, 11) == 0);
            dr     = ($urandom_range(0, 9) == 0);
            pp     = ($urandom_range(0, 2) != 0);
            rs     = ($urandom_range(0, 199) == 0);
            applyStimulus(btn, dr, pp, rs, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
